// File: rtl/cam_capture_wr.sv
// rtl/cam_capture_wr.sv - OV7670 RGB565 byte-stream capture to RGB332 frame-buffer writes
// One write per complete pixel at row*IMG_W+col; rows/cols beyond the image are dropped.
module cam_capture_wr #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          line_err
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] W_MAX  = CW'(IMG_W);
  localparam logic [RW-1:0] H_MAX  = RW'(IMG_H);
  localparam logic [AW-1:0] W_STEP = AW'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_ROW_WAIT, S_BYTE1, S_BYTE2, S_FRAME_END
  } state_t;

  state_t        r_state, w_next;
  logic          r_vsync_q;
  logic [7:0]    r_b1;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wr;
  logic          r_line_err;

  logic w_frame_start, w_vs_rise;
  logic w_latch_b1, w_pix, w_eol, w_half_err, w_clear, w_frame_done;

  assign w_frame_start = r_vsync_q & ~vsync;
  assign w_vs_rise     = vsync & ~r_vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (init) w_next = S_WAIT_FRAME;
      S_WAIT_FRAME: if (w_frame_start) w_next = S_ROW_WAIT;
      S_ROW_WAIT: begin
        if (w_vs_rise)  w_next = S_FRAME_END;
        else if (href)  w_next = S_BYTE2;
      end
      S_BYTE2: begin
        if (w_vs_rise)  w_next = S_FRAME_END;
        else if (!href) w_next = S_ROW_WAIT;
        else            w_next = S_BYTE1;
      end
      S_BYTE1: begin
        if (w_vs_rise)  w_next = S_FRAME_END;
        else if (!href) w_next = S_ROW_WAIT;
        else            w_next = S_BYTE2;
      end
      S_FRAME_END:  w_next = init ? S_WAIT_FRAME : S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // A vsync rise inside a line closes it like href falling; a pending first byte is an error.
  always_comb begin
    w_latch_b1   = 1'b0;
    w_pix        = 1'b0;
    w_eol        = 1'b0;
    w_half_err   = 1'b0;
    w_clear      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_WAIT_FRAME: w_clear = w_frame_start;
      S_ROW_WAIT:   w_latch_b1 = href & ~w_vs_rise;
      S_BYTE2: begin
        if (w_vs_rise || !href) begin
          w_eol      = 1'b1;
          w_half_err = 1'b1;
        end else begin
          w_pix = 1'b1;
        end
      end
      S_BYTE1: begin
        if (w_vs_rise || !href) w_eol = 1'b1;
        else                    w_latch_b1 = 1'b1;
      end
      S_FRAME_END:  w_frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_q  <= 1'b0;
      r_b1       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_wr      <= 1'b0;
      if (w_latch_b1) r_b1 <= px_data;
      if (w_pix) begin
        if (r_col < W_MAX && r_row < H_MAX) begin
          r_wr   <= 1'b1;
          r_addr <= r_base + AW'(r_col);
          r_data <= DW'({r_b1[7:5], r_b1[2:0], px_data[4:3]});
        end
        if (r_col < W_MAX) r_col <= r_col + CW'(1);
      end
      // Empty lines (no complete pixel) leave the row untouched.
      if (w_eol && r_col != '0) begin
        r_col <= '0;
        if (r_row < H_MAX) begin
          r_row  <= r_row + RW'(1);
          r_base <= r_base + W_STEP;
        end
      end
      if (w_half_err) r_line_err <= 1'b1;
      if (w_clear) begin
        r_col      <= '0;
        r_row      <= '0;
        r_base     <= '0;
        r_line_err <= 1'b0;
      end
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_data;
  assign px_wr       = r_wr;
  assign frame_done  = w_frame_done;
  assign line_err    = r_line_err;

endmodule

// File: tb/tb_cam_capture_wr.sv
// tb/tb_cam_capture_wr.sv - randomized bench for cam_capture_wr against a frame-level model
// The model derives every write address as row*IMG_W+pixel and data from the RGB565->RGB332 rule.
module tb_cam_capture_wr;
  localparam int AW = 15, DW = 8, IMG_W = 160, IMG_H = 120;

  logic          clk = 1'b0;
  logic          rst, init, vsync, href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, frame_done, line_err;

  cam_capture_wr #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .init(init), .vsync(vsync), .href(href), .px_data(px_data),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
    .frame_done(frame_done), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int n_fd = 0, n_wr = 0;
  int last_addr = -1, last_data = -1;
  int eq_addr[$], eq_data[$];
  int m_row, fd0;
  bit m_cap, m_err;
  bit pat_fixed;
  logic [7:0] p1, p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rgb332(input logic [7:0] b1, input logic [7:0] b2);
    return int'({b1[7:5], b1[2:0], b2[4:3]});
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) n_fd++;
      if (px_wr) begin
        n_wr++;
        last_addr = int'(mem_px_addr);
        last_data = int'(mem_px_data);
        if (eq_addr.size() == 0) chk("unexpected_wr", px_wr, 1'b0);
        else begin
          chk("wr_addr", mem_px_addr, eq_addr.pop_front());
          chk("wr_data", mem_px_data, eq_data.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int nbytes);
    logic [7:0] b, b1;
    b1 = '0;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      b = pat_fixed ? ((i % 2 == 0) ? p1 : p2) : 8'($urandom);
      href = 1'b1;
      px_data = b;
      if (i % 2 == 0) b1 = b;
      else if (m_cap && m_row < IMG_H && i / 2 < IMG_W) begin
        eq_addr.push_back(m_row * IMG_W + i / 2);
        eq_data.push_back(rgb332(b1, b));
      end
    end
  endtask

  task automatic send_line(input int nbytes);
    send_bytes(nbytes);
    @(posedge clk); #1;
    href = 1'b0;
    px_data = 8'($urandom);
    if (m_cap) begin
      if (nbytes % 2 == 1) m_err = 1'b1;
      if (nbytes >= 2) m_row++;
    end
    tick(3);
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    vsync = 1'b0;
    if (m_cap) begin m_row = 0; m_err = 1'b0; end
    fd0 = n_fd;
    tick(3);
  endtask

  task automatic frame_end();
    tick(2);
    vsync = 1'b1;
    tick(6);
    chk("frame_done_cnt", n_fd - fd0, m_cap ? 1 : 0);
    chk("pending_writes", eq_addr.size(), 0);
    if (m_cap) chk("line_err_end", line_err, m_err);
  endtask

  initial begin
    int w0;
    rst = 1'b1; init = 1'b0; vsync = 1'b1; href = 1'b0; px_data = '0;
    pat_fixed = 1'b0; p1 = '0; p2 = '0; m_cap = 1'b0; m_err = 1'b0; m_row = 0; fd0 = 0;

    // Reset with random inputs, then an ignored frame with init low
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      {init, vsync, href} = 3'($urandom);
      px_data = 8'($urandom);
      @(negedge clk);
      chk("rst_outputs", {px_wr, frame_done, line_err, mem_px_addr, mem_px_data}, '0);
    end
    @(posedge clk); #1;
    init = 1'b0; vsync = 1'b1; href = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    m_cap = 1'b0;
    frame_start();
    for (int l = 0; l < 5; l++) send_line(40);
    frame_end();

    // Full 160x120 frame of constant colour
    init = 1'b1;
    tick(3);
    m_cap = 1'b1;
    frame_start();
    w0 = n_wr;
    pat_fixed = 1'b1; p1 = 8'hF8; p2 = 8'h00;
    for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W);
    chk("full_frame_wr_cnt", n_wr - w0, IMG_W * IMG_H);
    chk("full_frame_last_addr", last_addr, IMG_W * IMG_H - 1);
    chk("full_frame_data", last_data, 8'hE0);
    frame_end();

    // Colour conversion corners
    frame_start();
    p1 = 8'h07; p2 = 8'hFF;
    send_line(6);
    chk("rgb_07ff", last_data, 8'h1F);
    p1 = 8'hAB; p2 = 8'hCD;
    send_line(4);
    chk("rgb_abcd", last_data, 8'hAD);
    pat_fixed = 1'b0;
    send_line(30);
    frame_end();

    // Long line then short line
    frame_start();
    send_line(340);
    chk("long_line_last", last_addr, IMG_W - 1);
    send_line(200);
    chk("short_line_last", last_addr, 259);
    send_line(10);
    chk("next_row_start", last_addr, 2 * IMG_W + 4);
    frame_end();

    // Odd-length line and a 130-line frame
    frame_start();
    w0 = n_wr;
    send_line(7);
    chk("odd_line_wr_cnt", n_wr - w0, 3);
    chk("odd_line_err", line_err, 1'b1);
    for (int l = 1; l < IMG_H - 1; l++) send_line($urandom_range(2, 10));
    send_line(2 * IMG_W);
    chk("last_row_addr", last_addr, IMG_W * IMG_H - 1);
    w0 = n_wr;
    for (int l = IMG_H; l < 130; l++) send_line($urandom_range(2, 40));
    chk("extra_lines_wr_cnt", n_wr - w0, 0);
    chk("err_sticky", line_err, 1'b1);
    frame_end();
    frame_start();
    chk("err_cleared", line_err, 1'b0);
    send_line(12);
    frame_end();

    // Random frames: line lengths include empty, single-byte, odd and overlong
    for (int f = 0; f < 3; f++) begin
      frame_start();
      for (int l = 0; l < $urandom_range(2, 6); l++) send_line($urandom_range(0, 360));
      frame_end();
    end

    // Asynchronous reset mid-line right after the write to address 500
    frame_start();
    for (int l = 0; l < 3; l++) send_line(2 * IMG_W);
    send_bytes(42);
    @(posedge clk); #2;
    chk("pre_rst_wr", px_wr, 1'b1);
    chk("pre_rst_addr", mem_px_addr, 500);
    rst = 1'b1;
    href = 1'b0;
    #1;
    chk("async_rst_outputs", {px_wr, frame_done, line_err, mem_px_addr, mem_px_data}, '0);
    eq_addr.delete();
    eq_data.delete();
    tick(2);
    rst = 1'b0;
    tick(4);
    vsync = 1'b1;
    tick(6);
    frame_start();
    send_line(20);
    chk("restart_last_addr", last_addr, 9);
    init = 1'b0;
    send_line(24);
    frame_end();
    m_cap = 1'b0;
    w0 = n_wr;
    frame_start();
    for (int l = 0; l < 4; l++) send_line(30);
    frame_end();
    chk("after_init_drop_wr", n_wr - w0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
